// File: rtl/if_fetch_stage_pkg.sv
// Shared pipeline definitions: word width, fetch FSM encoding, bubble word
// and the PC increment helper.
package if_fetch_stage_pkg;

   localparam int WORD_W = 32;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DROP  = 2'd1,
      SKID  = 2'd2
   } fetch_state_t;

   // Condition field NV: decode nullifies this word.
   localparam logic [WORD_W-1:0] BUBBLE_INSTR = 32'hF000_0000;

   function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
      return pc + WORD_W'(4);
   endfunction

endpackage

// File: rtl/if_fetch_stage_if_id_reg.sv
// IF/ID pipeline register: reset, flush-to-bubble, load and hold, in that
// priority. A flush keeps pc_out so decode still sees the last real PC.
module if_id_reg
   import if_fetch_stage_pkg::*;
#(
   parameter logic [WORD_W-1:0] BUBBLE = BUBBLE_INSTR
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              load,
   input  logic              flush,
   input  logic [WORD_W-1:0] load_pc,
   input  logic [WORD_W-1:0] load_instr,
   output logic [WORD_W-1:0] pc_out,
   output logic [WORD_W-1:0] instruction,
   output logic              valid
);

   // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         pc_out      <= '0;
         instruction <= BUBBLE;
         valid       <= 1'b0;
      end else if (flush) begin
         instruction <= BUBBLE;
         valid       <= 1'b0;
      end else if (load) begin
         pc_out      <= load_pc;
         instruction <= load_instr;
         valid       <= 1'b1;
      end
   end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, req/ready fetch FSM with skid buffer for
// frozen completions and a DROP state that swallows wrong-path returns.
module if_fetch_stage
   import if_fetch_stage_pkg::WORD_W, if_fetch_stage_pkg::fetch_state_t,
          if_fetch_stage_pkg::FETCH, if_fetch_stage_pkg::DROP,
          if_fetch_stage_pkg::SKID, if_fetch_stage_pkg::next_pc;
#(
   parameter logic [31:0] RESET_PC     = 32'h0000_0000,
   parameter logic [31:0] BUBBLE_INSTR = if_fetch_stage_pkg::BUBBLE_INSTR
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        freeze,
   input  logic        branch_taken,
   input  logic [31:0] branch_addr,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_ready,
   input  logic [31:0] imem_rdata,
   output logic [31:0] pc_out,
   output logic [31:0] instruction,
   output logic        valid
);

   fetch_state_t      state_q, state_d;
   logic [WORD_W-1:0] pc_q, pc_d;
   logic [WORD_W-1:0] drop_addr_q;
   logic [WORD_W-1:0] skid_pc_q, skid_instr_q;

   logic              transfer;
   logic              ifid_load, ifid_flush;
   logic [WORD_W-1:0] ifid_pc, ifid_instr;
   logic              skid_load, drop_load;

   assign imem_req  = !rst && ((state_q == FETCH) || (state_q == DROP));
   assign imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
   assign transfer  = imem_req && imem_ready;

   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      state_d    = state_q;
      pc_d       = pc_q;
      ifid_load  = 1'b0;
      ifid_flush = 1'b0;
      ifid_pc    = skid_pc_q;
      ifid_instr = skid_instr_q;
      skid_load  = 1'b0;
      drop_load  = 1'b0;

      if (branch_taken) begin
         // Any return landing this cycle is wrong-path; a still-pending one
         // must be drained in DROP before the target can be requested.
         pc_d       = branch_addr;
         ifid_flush = 1'b1;
         drop_load  = 1'b1;
         state_d    = (imem_req && !imem_ready) ? DROP : FETCH;
      end else begin
         case (state_q)
            FETCH: begin
               if (transfer) begin
                  pc_d = next_pc(pc_q);
                  if (freeze) begin
                     skid_load = 1'b1;
                     state_d   = SKID;
                  end else begin
                     ifid_load  = 1'b1;
                     ifid_pc    = next_pc(pc_q);
                     ifid_instr = imem_rdata;
                  end
               end else if (!freeze) begin
                  ifid_flush = 1'b1;
               end
            end
            DROP: begin
               if (transfer) state_d = FETCH;
               if (!freeze) ifid_flush = 1'b1;
            end
            SKID: begin
               if (!freeze) begin
                  ifid_load = 1'b1;
                  state_d   = FETCH;
               end
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= FETCH;
         pc_q    <= RESET_PC;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
      end
   end

   // NOTE: skid and drop-address data need no reset; the state says when they are live.
   always_ff @(posedge clk) begin
      if (skid_load) begin
         skid_pc_q    <= next_pc(pc_q);
         skid_instr_q <= imem_rdata;
      end
      if (drop_load) drop_addr_q <= imem_addr;
   end

   if_id_reg #(
      .BUBBLE (BUBBLE_INSTR)
   ) u_if_id_reg (
      .clk         (clk),
      .rst         (rst),
      .load        (ifid_load),
      .flush       (ifid_flush),
      .load_pc     (ifid_pc),
      .load_instr  (ifid_instr),
      .pc_out      (pc_out),
      .instruction (instruction),
      .valid       (valid)
   );

endmodule
